// File: rtl/vga_sched_pkg.sv
// Shared types and screen-derived defaults for the vblank update scheduler.
// Timing is 640x480@60: 800 pixel clocks per line, 525 lines per frame.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GRANT,
    WAIT_END
  } sched_state_t;

  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL   = 525;

  localparam int DEFAULT_V_RES = V_VISIBLE;
  // One grant may use up to 25 lines of the 45-line blanking interval.
  localparam int DEFAULT_TIMEOUT = 25 * H_TOTAL;

endpackage

// File: rtl/lsb_onehot_pick.sv
// Combinational lowest-set-bit picker: one-hot of the lowest set bit of req,
// plus a flag that at least one bit was set.
module lsb_onehot_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic         valid
);

  // seen[i] is high when any bit below i is set.
  logic [N:0] seen;

  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pick
      assign onehot[gi]   = req[gi] & ~seen[gi];
      assign seen[gi + 1] = seen[gi] | req[gi];
    end
  endgenerate

  assign valid = seen[N];

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants exclusive, fixed-priority update windows to game-logic requesters
// during vertical blanking; one frame tick and at most one grant per requester per frame.
module vblank_update_scheduler
  import vga_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int Y_W         = 10,
  parameter int V_RES       = DEFAULT_V_RES,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [Y_W-1:0]         pixel_y_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       done_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic                   frame_tick_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic                   overrun_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int             TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  sched_state_t           state_reg, state_next;
  logic [N_REQ-1:0]       pending_reg, pending_next;
  logic [N_REQ-1:0]       sel_reg, sel_next;
  logic [TO_W-1:0]        to_cnt_reg, to_cnt_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic                   vblank_reg;
  logic                   tick_reg, tick_next;
  logic                   timeout_reg, timeout_next;
  logic                   overrun_reg, overrun_next;

  logic                   vblank;
  logic                   vblank_rise;
  logic                   vblank_fall;
  logic                   done_hit;
  logic                   to_hit;
  logic [N_REQ-1:0]       pick_onehot;
  logic                   pick_valid;

  assign vblank      = (pixel_y_i >= Y_W'(V_RES));
  assign vblank_rise = vblank & ~vblank_reg;
  assign vblank_fall = ~vblank & vblank_reg;
  assign done_hit    = (state_reg == GRANT) && |(done_i & sel_reg);
  assign to_hit      = (to_cnt_reg == TO_LAST);

  lsb_onehot_pick #(
    .N(N_REQ)
  ) u_pick (
    .req   (pending_reg),
    .onehot(pick_onehot),
    .valid (pick_valid)
  );

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    sel_next       = sel_reg;
    to_cnt_next    = to_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    tick_next      = 1'b0;
    timeout_next   = 1'b0;
    overrun_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // The tick cycle holds the freshly latched mask; scanning starts after it.
        if (tick_reg) begin
          if (vblank_fall) begin
            pending_next = '0;
          end else begin
            state_next = SCAN;
          end
        end else if (vblank_rise) begin
          tick_next      = 1'b1;
          frame_cnt_next = frame_cnt_reg + FRAME_CNT_W'(1);
          pending_next   = req_i;
        end
      end

      SCAN: begin
        if (vblank_fall) begin
          overrun_next = |pending_reg;
          pending_next = '0;
          state_next   = IDLE;
        end else if (pick_valid) begin
          sel_next    = pick_onehot;
          to_cnt_next = '0;
          state_next  = GRANT;
        end else begin
          state_next = WAIT_END;
        end
      end

      GRANT: begin
        if (vblank_fall) begin
          // A grant finishing on the very last blanking cycle is not outstanding.
          overrun_next = done_hit ? |(pending_reg & ~sel_reg) : |pending_reg;
          pending_next = '0;
          state_next   = IDLE;
        end else if (done_hit) begin
          pending_next = pending_reg & ~sel_reg;
          state_next   = SCAN;
        end else if (to_hit) begin
          timeout_next = 1'b1;
          pending_next = pending_reg & ~sel_reg;
          state_next   = SCAN;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end

      WAIT_END: begin
        if (vblank_fall) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      sel_reg       <= '0;
      to_cnt_reg    <= '0;
      frame_cnt_reg <= '0;
      vblank_reg    <= 1'b1;
      tick_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      sel_reg       <= sel_next;
      to_cnt_reg    <= to_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      vblank_reg    <= vblank;
      tick_reg      <= tick_next;
      timeout_reg   <= timeout_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign gnt_o        = (state_reg == GRANT) ? sel_reg : '0;
  assign busy_o       = (state_reg == SCAN) || (state_reg == GRANT);
  assign frame_tick_o = tick_reg;
  assign timeout_o    = timeout_reg;
  assign overrun_o    = overrun_reg;
  assign frame_cnt_o  = frame_cnt_reg;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler: grant sequencing, timeout,
// overrun, async reset and frame counter wrap.
module tb_vblank_update_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  pixel_y_i;
  logic [3:0]  req_i;
  logic [3:0]  done_i;
  logic [3:0]  gnt_o;
  logic        frame_tick_o;
  logic        busy_o;
  logic        timeout_o;
  logic        overrun_o;
  logic [15:0] frame_cnt_o;

  // Second instance with a narrow frame counter so the wrap fits a short run.
  logic [9:0]  wy;
  logic [3:0]  w_gnt;
  logic        w_tick;
  logic        w_busy;
  logic        w_to;
  logic        w_ov;
  logic [7:0]  w_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  vblank_update_scheduler #(
    .N_REQ(4), .Y_W(10), .V_RES(480), .TIMEOUT(8), .FRAME_CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pixel_y_i(pixel_y_i), .req_i(req_i), .done_i(done_i),
    .gnt_o(gnt_o), .frame_tick_o(frame_tick_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .overrun_o(overrun_o), .frame_cnt_o(frame_cnt_o)
  );

  vblank_update_scheduler #(
    .N_REQ(4), .Y_W(10), .V_RES(480), .TIMEOUT(8), .FRAME_CNT_W(8)
  ) u_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .pixel_y_i(wy), .req_i(4'b0000), .done_i(4'b0000),
    .gnt_o(w_gnt), .frame_tick_o(w_tick), .busy_o(w_busy), .timeout_o(w_to),
    .overrun_o(w_ov), .frame_cnt_o(w_cnt)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; pixel_y_i = 10'd0; req_i = 4'b0; done_i = 4'b0; wy = 10'd0;
    step(); step();
    checks++;
    if ({gnt_o, frame_tick_o, busy_o, timeout_o, overrun_o} !== 8'h00) begin
      failures++; $display("FAIL reset_outputs got=%b want=00000000", {gnt_o, frame_tick_o, busy_o, timeout_o, overrun_o});
    end
    checks++;
    if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt_o); end
    rst_i = 1'b0;
    step();
    $display("reset released");
  endtask

  task automatic test_priority_sequence();
    pixel_y_i = 10'd479; req_i = 4'b0101;
    step();
    pixel_y_i = 10'd480;
    step();
    checks++;
    if (frame_tick_o !== 1'b1) begin failures++; $display("FAIL seq_tick got=%b want=1", frame_tick_o); end
    checks++;
    if (frame_cnt_o !== 16'd1) begin failures++; $display("FAIL seq_frame_cnt got=%0d want=1", frame_cnt_o); end
    checks++;
    if (gnt_o !== 4'b0000) begin failures++; $display("FAIL seq_gnt_t1 got=%b want=0000", gnt_o); end
    req_i = 4'b1111;  // arrives after sampling, must wait for the next frame
    step();
    checks++;
    if ({frame_tick_o, busy_o, gnt_o} !== 6'b010000) begin
      failures++; $display("FAIL seq_scan got=%b want=010000", {frame_tick_o, busy_o, gnt_o});
    end
    step();
    checks++;
    if (gnt_o !== 4'b0001) begin failures++; $display("FAIL seq_gnt0 got=%b want=0001", gnt_o); end
    done_i = 4'b0001;
    step();
    done_i = 4'b0000;
    checks++;
    if (gnt_o !== 4'b0000) begin failures++; $display("FAIL seq_gnt_drop got=%b want=0000", gnt_o); end
    step();
    checks++;
    if (gnt_o !== 4'b0100) begin failures++; $display("FAIL seq_gnt2 got=%b want=0100", gnt_o); end
    done_i = 4'b0100;
    step();
    done_i = 4'b0000;
    step();
    checks++;
    if ({busy_o, gnt_o} !== 5'b00000) begin failures++; $display("FAIL seq_wait_end got=%b want=00000", {busy_o, gnt_o}); end
    pixel_y_i = 10'd0;
    step();
    checks++;
    if (overrun_o !== 1'b0) begin failures++; $display("FAIL seq_no_overrun got=%b want=0", overrun_o); end
    $display("frame 1: priority sequence 0101 served");
  endtask

  task automatic test_timeout();
    req_i = 4'b0010; pixel_y_i = 10'd480;
    step();
    checks++;
    if (frame_cnt_o !== 16'd2) begin failures++; $display("FAIL to_frame_cnt got=%0d want=2", frame_cnt_o); end
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({gnt_o, timeout_o} !== 5'b00100) begin
        failures++; $display("FAIL to_hold cycle=%0d got=%b want=00100", i, {gnt_o, timeout_o});
      end
    end
    step();
    checks++;
    if ({gnt_o, timeout_o, busy_o} !== 6'b000011) begin
      failures++; $display("FAIL to_pulse got=%b want=000011", {gnt_o, timeout_o, busy_o});
    end
    step();
    checks++;
    if ({timeout_o, busy_o} !== 2'b00) begin failures++; $display("FAIL to_after got=%b want=00", {timeout_o, busy_o}); end
    pixel_y_i = 10'd0;
    step();
    $display("frame 2: grant 0010 revoked by timeout");
  endtask

  task automatic test_done_vs_timeout();
    req_i = 4'b0110; pixel_y_i = 10'd480;
    step(); step();
    step();
    checks++;
    if (gnt_o !== 4'b0010) begin failures++; $display("FAIL dvt_gnt1 got=%b want=0010", gnt_o); end
    done_i = 4'b1101;  // non-granted bits, including pending bit 2
    step();
    done_i = 4'b0000;
    checks++;
    if (gnt_o !== 4'b0010) begin failures++; $display("FAIL dvt_ignore got=%b want=0010", gnt_o); end
    for (int i = 0; i < 6; i++) step();
    done_i = 4'b0010;  // last permitted grant cycle
    step();
    done_i = 4'b0000;
    checks++;
    if ({timeout_o, gnt_o, busy_o} !== 6'b000001) begin
      failures++; $display("FAIL dvt_done_wins got=%b want=000001", {timeout_o, gnt_o, busy_o});
    end
    step();
    checks++;
    if (gnt_o !== 4'b0100) begin failures++; $display("FAIL dvt_gnt2 got=%b want=0100", gnt_o); end
    done_i = 4'b0100;
    step();
    done_i = 4'b0000;
    step();
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL dvt_wait_end got=%b want=0", busy_o); end
    pixel_y_i = 10'd0;
    step();
    $display("frame 3: done beats timeout, stray done ignored");
  endtask

  task automatic test_overrun();
    logic [3:0] exp_g;
    req_i = 4'b1111; pixel_y_i = 10'd480;
    step(); step(); step();
    done_i = 4'b0001;
    step();
    done_i = 4'b0000;
    step();
    checks++;
    if (gnt_o !== 4'b0010) begin failures++; $display("FAIL ovr_gnt1 got=%b want=0010", gnt_o); end
    pixel_y_i = 10'd0;
    step();
    checks++;
    if ({overrun_o, gnt_o, busy_o} !== 6'b100000) begin
      failures++; $display("FAIL ovr_pulse got=%b want=100000", {overrun_o, gnt_o, busy_o});
    end
    step();
    checks++;
    if (overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_single got=%b want=0", overrun_o); end
    $display("frame 4: overrun while bit 1 granted");
    pixel_y_i = 10'd480;
    step();
    checks++;
    if ({frame_tick_o, frame_cnt_o} !== {1'b1, 16'd5}) begin
      failures++; $display("FAIL refill_tick got=%b/%0d want=1/5", frame_tick_o, frame_cnt_o);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      step();
      checks++;
      if (gnt_o !== exp_g) begin failures++; $display("FAIL refill_gnt k=%0d got=%b want=%b", k, gnt_o, exp_g); end
      done_i = exp_g;
      step();
      done_i = 4'b0000;
    end
    step();
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL refill_wait_end got=%b want=0", busy_o); end
    pixel_y_i = 10'd0;
    step();
    $display("frame 5: all four requesters served");
  endtask

  task automatic test_reset_mid_grant();
    req_i = 4'b0001; pixel_y_i = 10'd480;
    step(); step(); step();
    checks++;
    if (gnt_o !== 4'b0001) begin failures++; $display("FAIL rst_pre_gnt got=%b want=0001", gnt_o); end
    #2;
    rst_i = 1'b1; pixel_y_i = 10'd500;
    #1;
    checks++;
    if ({gnt_o, frame_tick_o, busy_o, timeout_o, overrun_o, frame_cnt_o} !== 24'h000000) begin
      failures++; $display("FAIL rst_async got=%h want=000000", {gnt_o, frame_tick_o, busy_o, timeout_o, overrun_o, frame_cnt_o});
    end
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({frame_tick_o, busy_o, gnt_o, frame_cnt_o} !== 22'd0) begin
        failures++; $display("FAIL rst_no_tick cycle=%0d got=%h want=0", i, {frame_tick_o, busy_o, gnt_o, frame_cnt_o});
      end
    end
    pixel_y_i = 10'd479;
    step();
    req_i = 4'b0000; pixel_y_i = 10'd480;
    step();
    checks++;
    if ({frame_tick_o, frame_cnt_o} !== {1'b1, 16'd1}) begin
      failures++; $display("FAIL rst_next_tick got=%b/%0d want=1/1", frame_tick_o, frame_cnt_o);
    end
    step(); step();
    checks++;
    if ({busy_o, gnt_o} !== 5'b00000) begin failures++; $display("FAIL rst_empty_frame got=%b want=00000", {busy_o, gnt_o}); end
    pixel_y_i = 10'd0;
    step();
    $display("reset mid-grant: tick only on next 479->480");
  endtask

  task automatic test_frame_wrap();
    checks++;
    if (w_cnt !== 8'd0) begin failures++; $display("FAIL wrap_start got=%0d want=0", w_cnt); end
    for (int f = 1; f <= 257; f++) begin
      wy = 10'd480;
      step();
      checks++;
      if (w_gnt !== 4'b0000) begin failures++; $display("FAIL wrap_gnt_hi f=%0d got=%b want=0000", f, w_gnt); end
      if (f == 1) begin
        checks++;
        if (w_tick !== 1'b1) begin failures++; $display("FAIL wrap_tick got=%b want=1", w_tick); end
      end
      wy = 10'd0;
      step();
      checks++;
      if (w_gnt !== 4'b0000) begin failures++; $display("FAIL wrap_gnt_lo f=%0d got=%b want=0000", f, w_gnt); end
      if (f == 256) begin
        checks++;
        if (w_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d want=0", w_cnt); end
      end
    end
    checks++;
    if (w_cnt !== 8'd1) begin failures++; $display("FAIL wrap_one got=%0d want=1", w_cnt); end
    $display("wrap: 257 empty frames, counter now %0d", w_cnt);
  endtask

  initial begin
    test_reset();
    test_priority_sequence();
    test_timeout();
    test_done_vs_timeout();
    test_overrun();
    test_reset_mid_grant();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
